decode_stage: RTL

//  Consumes the raw instruction stream from the fetch stage (opcode/uop_valid_out) through a

---
 rtl/decode_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction queue feeding a registered RV32I decoder with valid/ready output.
// Define RV32M_DECODE_EN to decode OP funct7=0000001 as the MULDIV class instead of ILLEGAL.
module decode_stage #(
   parameter int INST_WIDTH      = 32,
   parameter int QUEUE_DEPTH     = 4,
   parameter int STALL_THRESHOLD = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INST_WIDTH-1:0] opcode,
   input  logic                  uop_valid_in,
   output logic                  stall_out,
   input  logic                  exec_ready,
   output logic                  dec_valid,
   output logic [INST_WIDTH-1:0] dec_inst,
   output logic [3:0]            dec_class,
   output logic [4:0]            dec_rd,
   output logic [4:0]            dec_rs1,
   output logic [4:0]            dec_rs2,
   output logic [2:0]            dec_funct3,
   output logic [31:0]           dec_imm,
   output logic                  dec_illegal,
   output logic                  q_overflow
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(QUEUE_DEPTH);
   localparam logic [PW:0] THR_C   = (PW+1)'(STALL_THRESHOLD);
   localparam logic [3:0] C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3,
                          C_BR = 4'd4, C_LD = 4'd5, C_ST = 4'd6, C_OPIMM = 4'd7, C_OP = 4'd8,
                          C_FENCE = 4'd9, C_SYS = 4'd10, C_MULDIV = 4'd11, C_ILL = 4'd15;

   logic [INST_WIDTH-1:0] mem_q [QUEUE_DEPTH];
   logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
   logic [PW:0]           count_q, count_d;
   logic                  dec_valid_q, dec_valid_d, q_overflow_q;
   logic [INST_WIDTH-1:0] dec_inst_q;
   logic [3:0]            dec_class_q;
   logic [4:0]            dec_rd_q, dec_rs1_q, dec_rs2_q;
   logic [2:0]            dec_funct3_q;
   logic [31:0]           dec_imm_q;
   logic                  push, load, full, m_ok;
   logic [INST_WIDTH-1:0] h;
   logic [2:0]            f3;
   logic [6:0]            f7;
   logic [3:0]            cls;
   logic [31:0]           imm, imm_i, imm_s, imm_b, imm_u, imm_j;
   logic                  ill;

`ifdef RV32M_DECODE_EN
   assign m_ok = 1'b1;
`else
   assign m_ok = 1'b0;
`endif

   assign full        = count_q == DEPTH_C;
   assign push        = uop_valid_in && !full;
   assign load        = count_q != '0 && (!dec_valid_q || exec_ready);
   assign count_d     = count_q + (PW+1)'(push) - (PW+1)'(load);
   assign dec_valid_d = load || (dec_valid_q && !exec_ready);
   assign stall_out   = (DEPTH_C - count_q) <= THR_C;

   assign h     = mem_q[rd_ptr_q];
   assign f3    = h[14:12];
   assign f7    = h[31:25];
   assign imm_i = {{20{h[31]}}, h[31:20]};
   assign imm_s = {{20{h[31]}}, h[31:25], h[11:7]};
   assign imm_b = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
   assign imm_u = {h[31:12], 12'b0};
   assign imm_j = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};

   // Unlisted opcodes, including any with inst[1:0]!=11 and all-zero words, fall to ILLEGAL
   always_comb begin
      cls = C_ILL;
      imm = '0;
      case (h[6:0])
         7'b0110111: begin cls = C_LUI; imm = imm_u; end
         7'b0010111: begin cls = C_AUIPC; imm = imm_u; end
         7'b1101111: begin cls = C_JAL; imm = imm_j; end
         7'b1100111: begin cls = f3 == 3'b000 ? C_JALR : C_ILL; imm = imm_i; end
         7'b1100011: begin cls = f3[2:1] == 2'b01 ? C_ILL : C_BR; imm = imm_b; end
         7'b0000011: begin cls = (f3 == 3'b011 || f3[2:1] == 2'b11) ? C_ILL : C_LD; imm = imm_i; end
         7'b0100011: begin cls = f3 < 3'b011 ? C_ST : C_ILL; imm = imm_s; end
         7'b0010011: begin
            cls = ((f3 == 3'b001 && f7 != 7'b0) ||
                   (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000)) ? C_ILL : C_OPIMM;
            imm = imm_i;
         end
         7'b0110011: cls = (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) ? C_OP :
                           (f7 == 7'b0000001 && m_ok) ? C_MULDIV : C_ILL;
         7'b0001111: begin cls = C_FENCE; imm = imm_i; end
         7'b1110011: begin cls = C_SYS; imm = imm_i; end
         default: ;
      endcase
   end

   assign ill = cls == C_ILL;

   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= opcode;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         dec_valid_q  <= 1'b0;
         q_overflow_q <= 1'b0;
         dec_inst_q   <= '0;
         dec_class_q  <= '0;
         dec_rd_q     <= '0;
         dec_rs1_q    <= '0;
         dec_rs2_q    <= '0;
         dec_funct3_q <= '0;
         dec_imm_q    <= '0;
      end else begin
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_q + PW'(load);
         wr_ptr_q     <= wr_ptr_q + PW'(push);
         dec_valid_q  <= dec_valid_d;
         q_overflow_q <= q_overflow_q || (uop_valid_in && full);
         if (load) begin
            dec_inst_q   <= h;
            dec_class_q  <= cls;
            dec_rd_q     <= ill ? 5'd0 : h[11:7];
            dec_rs1_q    <= ill ? 5'd0 : h[19:15];
            dec_rs2_q    <= ill ? 5'd0 : h[24:20];
            dec_funct3_q <= f3;
            dec_imm_q    <= ill ? 32'd0 : imm;
         end
      end
   end

   assign dec_valid   = dec_valid_q;
   assign dec_inst    = dec_inst_q;
   assign dec_class   = dec_class_q;
   assign dec_rd      = dec_rd_q;
   assign dec_rs1     = dec_rs1_q;
   assign dec_rs2     = dec_rs2_q;
   assign dec_funct3  = dec_funct3_q;
   assign dec_imm     = dec_imm_q;
   assign dec_illegal = dec_class_q == C_ILL;
   assign q_overflow  = q_overflow_q;
endmodule
